// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: FSM states, default widths
// and the instruction-buffer entry layout.
package cpuPkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] instr;
  } buf_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Instruction buffer: synchronous FIFO with wrap-bit pointers, flush that
// wins over push/pop, and a head taken directly from the storage registers.
module fetch_buffer
  import cpuPkg::*;
#(
  parameter type entry_t = buf_entry_t,
  parameter int  DEPTH   = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  input  logic   flush_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

  logic [IDX_W:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0] rd_ptr_q, rd_ptr_d;
  entry_t         mem_q [DEPTH];
  logic           do_push_s;
  logic           do_pop_s;

  // Same index with differing wrap bits means every slot is occupied.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign head_o    = mem_q[rd_ptr_q[IDX_W-1:0]];
  assign do_push_s = push_i && !full_o && !flush_i;
  assign do_pop_s  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
      else           wr_ptr_d = wr_ptr_q;
      if (do_pop_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      else           rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push_s) mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory request FSM feeding a
// small instruction buffer. FETCH_MISALIGN_TRAP_EN adds misalignTrap.
module fetch_unit
  import cpuPkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pcIn,
  output logic              pcCount,
  input  logic              flush,
  output logic              memReqValid,
  input  logic              memReqReady,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memRespValid,
  input  logic [DATA_W-1:0] memRespData,
  output logic              instrValid,
  input  logic              instrReady,
  output logic [DATA_W-1:0] instrOut,
  output logic [ADDR_W-1:0] instrPc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic              misalignTrap
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              buf_full_s, buf_empty_s;
  logic              push_s;
  logic              issue_ok_s;
  logic              misaligned_s;
  entry_t            push_entry_s;
  entry_t            head_s;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic              trap_q;
  logic              trap_set_s;

  assign issue_ok_s   = !flush && !buf_full_s && !trap_q;
  assign misaligned_s = (pcIn[1:0] != 2'b00);
  assign trap_set_s   = (state_q == IDLE) && issue_ok_s && misaligned_s;
  assign misalignTrap = trap_q;

  // Trap stays set until a redirect supplies a new program counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          trap_q <= 1'b0;
    else if (flush)      trap_q <= 1'b0;
    else if (trap_set_s) trap_q <= 1'b1;
    else                 trap_q <= trap_q;
  end
`else
  assign issue_ok_s   = !flush && !buf_full_s;
  assign misaligned_s = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    memReqValid  = 1'b0;
    pcCount      = 1'b0;
    push_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_ok_s && !misaligned_s) begin
          state_d      = REQ;
          fetch_addr_d = pcIn;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        memReqValid = 1'b1;
        // An accepted request still owes a response, so it must be drained.
        if (flush)            state_d = memReqReady ? DISCARD : IDLE;
        else if (memReqReady) state_d = WAIT;
        else                  state_d = REQ;
      end
      WAIT: begin
        if (flush) begin
          state_d = memRespValid ? IDLE : DISCARD;
        end else if (memRespValid) begin
          push_s  = 1'b1;
          pcCount = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      DISCARD: begin
        if (memRespValid) state_d = IDLE;
        else              state_d = DISCARD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

  assign push_entry_s = '{pc: fetch_addr_q, instr: memRespData};
  assign memAddr      = fetch_addr_q;
  assign instrValid   = !buf_empty_s;
  assign instrOut     = head_s.instr;
  assign instrPc      = head_s.pc;

  fetch_buffer #(
    .entry_t (entry_t),
    .DEPTH   (BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (instrValid && instrReady),
    .flush_i     (flush),
    .head_o      (head_s),
    .full_o      (buf_full_s),
    .empty_o     (buf_empty_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory/stimulus process predicts buffer
// entries into a scoreboard queue that an independent output monitor drains.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcIn;
  logic        pcCount;
  logic        flush;
  logic        memReqValid;
  logic        memReqReady;
  logic [31:0] memAddr;
  logic        memRespValid;
  logic [31:0] memRespData;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instrOut;
  logic [31:0] instrPc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalignTrap;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .BUF_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .pcIn         (pcIn),
    .pcCount      (pcCount),
    .flush        (flush),
    .memReqValid  (memReqValid),
    .memReqReady  (memReqReady),
    .memAddr      (memAddr),
    .memRespValid (memRespValid),
    .memRespData  (memRespData),
    .instrValid   (instrValid),
    .instrReady   (instrReady),
    .instrOut     (instrOut),
    .instrPc      (instrPc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalignTrap (misalignTrap)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] popped_pc[$];
  int          errors = 0;
  int          checks = 0;
  int          n_pops = 0;
  int          n_push = 0;
  int          n_acc  = 0;
  bit          mon_en = 1'b0;

  // Stimulus knobs (percentages and response delay range in cycles).
  int          p_rdy = 100, p_ird = 100, p_flush = 0, dly_min = 1, dly_max = 1;
  bit          use_force = 1'b0;
  logic [31:0] force_data = 32'h0;
  bit          flush_now = 1'b0, flush_on_acc = 1'b0, flush_at_one = 1'b0;
  logic [31:0] flush_pc = 32'h0;

  // Reference model: program counter and the single outstanding memory access.
  logic [31:0] pc_m = 32'h0;
  bit          outst = 1'b0, killed = 1'b0;
  int          cnt = 0;
  logic [31:0] o_addr = 32'h0, o_data = 32'h0, last_acc_addr = 32'h0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_pcCount", 32'(pcCount), 32'd0);
    chk("rst_memReqValid", 32'(memReqValid), 32'd0);
    chk("rst_memAddr", memAddr, 32'd0);
    chk("rst_instrValid", 32'(instrValid), 32'd0);
    chk("rst_instrOut", instrOut, 32'd0);
    chk("rst_instrPc", instrPc, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_misalignTrap", 32'(misalignTrap), 32'd0);
`endif
  endtask

  // Monitor: occupancy, issue gating and in-order head contents.
  always @(negedge clk) begin : monitor
    ent_t e;
    if (mon_en) begin
      chk("instr_valid", 32'(instrValid), 32'(exp_q.size() != 0));
      if (memReqValid) chk("no_issue_when_full", 32'(exp_q.size() < DEPTH), 32'd1);
      if (flush) begin
        exp_q.delete();
      end else if (instrValid && instrReady && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("instr_pc", instrPc, e.pc);
        chk("instr_out", instrOut, e.instr);
        popped_pc.push_back(instrPc);
        n_pops++;
      end
    end
  end

  // One clock of stimulus: evaluate the cycle, advance the model, drive next inputs.
  task automatic step();
    logic        deliver, acc, exp_cnt;
    logic [31:0] acc_addr;
    ent_t        e;
    @(negedge clk);
    deliver  = outst && memRespValid;
    exp_cnt  = deliver && !killed && !flush;
    chk("pc_count", 32'(pcCount), 32'(exp_cnt));
    acc      = memReqValid && memReqReady;
    acc_addr = memAddr;
    if (memReqValid && !flush) chk("mem_addr", memAddr, pc_m);
    if (acc) chk("one_outstanding", 32'(outst), 32'd0);
    @(posedge clk);
    if (exp_cnt) begin
      e.pc = o_addr;
      e.instr = o_data;
      exp_q.push_back(e);
      n_push++;
      pc_m = pc_m + 32'd4;
    end
    if (deliver) outst = 1'b0;
    else if (outst) begin
      if (flush) killed = 1'b1;
      if (cnt > 0) cnt--;
    end
    if (acc) begin
      outst = 1'b1;
      killed = flush;
      cnt = int'($urandom_range(dly_max, dly_min)) - 1;
      o_addr = acc_addr;
      o_data = use_force ? force_data : $urandom();
      last_acc_addr = acc_addr;
      n_acc++;
    end
    #1;
    memRespValid = outst && (cnt == 0);
    memRespData  = memRespValid ? o_data : $urandom();
    memReqReady  = int'($urandom_range(99, 0)) < p_rdy;
    instrReady   = int'($urandom_range(99, 0)) < p_ird;
    flush = 1'b0;
    if (flush_now) begin
      flush = 1'b1; flush_now = 1'b0; pc_m = flush_pc;
    end else if (flush_on_acc && acc) begin
      flush = 1'b1; flush_on_acc = 1'b0; pc_m = flush_pc;
    end else if (flush_at_one && exp_q.size() == 1) begin
      flush = 1'b1; instrReady = 1'b1; flush_at_one = 1'b0; pc_m = flush_pc;
    end else if (int'($urandom_range(99, 0)) < p_flush) begin
      flush = 1'b1; pc_m = 32'($urandom_range(1023, 0)) << 2;
    end
    pcIn = pc_m;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int guard, acc0, push0, pops0;
    reset = 1'b0; pcIn = 32'h0; flush = 1'b0; memReqReady = 1'b0;
    memRespValid = 1'b0; memRespData = 32'h0; instrReady = 1'b0;

    #23;
    chk_reset_outputs();
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #2;
    chk("post_reset_req_valid", 32'(memReqValid), 32'd1);
    chk("post_reset_addr", memAddr, 32'h0);
    mon_en = 1'b1;

    // Streaming with an always-ready, single-cycle memory.
    repeat (24) step();
    chk("stream_count", 32'(popped_pc.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) chk("stream_pc", popped_pc[i], 32'(i * 4));

    // Backpressure from decode, restarting at pc 0.
    p_ird = 0; flush_pc = 32'h0; flush_now = 1'b1;
    repeat (24) step();
    chk("bp_occupancy", 32'(exp_q.size()), 32'(DEPTH));
    chk("bp_head_valid", 32'(instrValid), 32'd1);
    chk("bp_head_pc", instrPc, 32'h0);
    chk("bp_no_req", 32'(memReqValid), 32'd0);
    acc0 = n_acc; p_ird = 100;
    repeat (12) step();
    chk("bp_resume", 32'(n_acc > acc0), 32'd1);

    // Flush while waiting on the response for pc 0x10.
    use_force = 1'b1; force_data = 32'hDEADBEEF; dly_min = 2; dly_max = 2;
    flush_pc = 32'h10; flush_now = 1'b1;
    step(); step();
    guard = 0;
    while (outst && guard < 20) begin step(); guard++; end
    chk("wait_drain_timeout", 32'(outst), 32'd0);
    flush_on_acc = 1'b1; flush_pc = 32'h40; push0 = n_push; acc0 = n_acc;
    guard = 0;
    while (n_acc == acc0 && guard < 20) begin step(); guard++; end
    chk("flush_wait_req_addr", last_acc_addr, 32'h10);
    acc0 = n_acc;
    guard = 0;
    while (n_acc == acc0 && guard < 20) begin step(); guard++; end
    chk("flush_wait_next_addr", last_acc_addr, 32'h40);
    chk("flush_wait_no_push", 32'(n_push), 32'(push0));
    chk("flush_wait_empty", 32'(instrValid), 32'd0);

    // Flush together with a pop of the only buffered entry.
    use_force = 1'b0; dly_min = 1; dly_max = 1; p_ird = 0;
    flush_pc = 32'h100; flush_at_one = 1'b1;
    guard = 0;
    while (flush_at_one && guard < 30) begin step(); guard++; end
    chk("fp_armed", 32'(flush_at_one), 32'd0);
    pops0 = n_pops;
    step();
    chk("fp_no_pop", 32'(n_pops), 32'(pops0));
    chk("fp_empty", 32'(instrValid), 32'd0);

    // Misaligned program counter.
    p_ird = 100; p_rdy = 0; flush_pc = 32'h6; flush_now = 1'b1;
    repeat (6) step();
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("trap_set", 32'(misalignTrap), 32'd1);
    chk("trap_no_req", 32'(memReqValid), 32'd0);
`else
    chk("misalign_req", 32'(memReqValid), 32'd1);
    chk("misalign_addr", memAddr, 32'h6);
`endif
    p_rdy = 100; flush_pc = 32'h20; flush_now = 1'b1;
    repeat (8) step();
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("trap_cleared", 32'(misalignTrap), 32'd0);
`endif

    // Random soak.
    p_rdy = 60; p_ird = 60; p_flush = 5; dly_min = 1; dly_max = 3;
    repeat (600) step();

    // Reset asserted while a request is pending.
    p_flush = 0; p_rdy = 0;
    guard = 0;
    while (!memReqValid && guard < 20) begin step(); guard++; end
    chk("rst_req_pending", 32'(memReqValid), 32'd1);
    @(posedge clk); #3;
    reset = 1'b0; mon_en = 1'b0;
    #1;
    chk_reset_outputs();
    exp_q.delete(); outst = 1'b0; killed = 1'b0; cnt = 0; pc_m = 32'h0;
    pcIn = 32'h0; flush = 1'b0; memRespValid = 1'b0; memReqReady = 1'b1; instrReady = 1'b1;
    @(posedge clk); #1; reset = 1'b1;
    mon_en = 1'b1; p_rdy = 100; p_ird = 100; push0 = n_push;
    repeat (20) step();
    chk("post_rst_fetch", 32'(n_push > push0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
